// File: rtl/rtc_calendar_counter.sv
// Real-time clock/calendar: prescaled 1 Hz advance of binary
// sec/min/hour/day/mon/year fields with range-checked load.
module rtc_calendar_counter #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int RESET_YEAR = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [5:0]  ld_sec,
    input  logic [5:0]  ld_min,
    input  logic [4:0]  ld_hour,
    input  logic [4:0]  ld_day,
    input  logic [3:0]  ld_mon,
    input  logic [13:0] ld_year,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [4:0]  day,
    output logic [3:0]  mon,
    output logic [13:0] year,
    output logic        tick,
    output logic        load_err
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_FREQ - 1);
    localparam logic [13:0] RST_YEAR = 14'(RESET_YEAR);

    function automatic logic leap(input logic [13:0] y);
        logic [13:0] r100;
        logic [13:0] r400;
        r100 = y % 14'd100;
        r400 = y % 14'd400;
        return ((y[1:0] == 2'd0) && (r100 != 14'd0)) || (r400 == 14'd0);
    endfunction

    function automatic logic [4:0] dim(input logic [3:0] m, input logic [13:0] y);
        case (m)
            4'd2:                   dim = leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            default:                dim = 5'd31;
        endcase
    endfunction

    logic [PW-1:0] presc;
    logic          adv;
    logic          ld_ok;
    logic          c_sec, c_min, c_hour, c_day, c_mon;
    logic [5:0]    n_sec, n_min;
    logic [4:0]    n_hour, n_day;
    logic [3:0]    n_mon;
    logic [13:0]   n_year;

    assign adv = en && (presc == PS_MAX);

    assign ld_ok = (ld_sec <= 6'd59) && (ld_min <= 6'd59) &&
                   (ld_hour <= 5'd23) &&
                   (ld_mon >= 4'd1) && (ld_mon <= 4'd12) &&
                   (ld_day >= 5'd1) && (ld_day <= dim(ld_mon, ld_year)) &&
                   (ld_year <= 14'd9999);

    // Full ripple carry resolved combinationally so all fields move together
    assign c_sec  = (sec == 6'd59);
    assign c_min  = c_sec && (min == 6'd59);
    assign c_hour = c_min && (hour == 5'd23);
    assign c_day  = c_hour && (day == dim(mon, year));
    assign c_mon  = c_day && (mon == 4'd12);

    always_comb begin
        n_sec  = c_sec ? 6'd0 : sec + 6'd1;
        n_min  = min;
        n_hour = hour;
        n_day  = day;
        n_mon  = mon;
        n_year = year;
        if (c_sec)
            n_min = (min == 6'd59) ? 6'd0 : min + 6'd1;
        if (c_min)
            n_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        if (c_hour)
            n_day = c_day ? 5'd1 : day + 5'd1;
        if (c_day)
            n_mon = c_mon ? 4'd1 : mon + 4'd1;
        if (c_mon)
            n_year = (year == 14'd9999) ? 14'd0 : year + 14'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day      <= 5'd1;
            mon      <= 4'd1;
            year     <= RST_YEAR;
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            load_err <= 1'b0;
            if (load && ld_ok) begin
                presc <= '0;
                sec   <= ld_sec;
                min   <= ld_min;
                hour  <= ld_hour;
                day   <= ld_day;
                mon   <= ld_mon;
                year  <= ld_year;
            end else begin
                if (load)
                    load_err <= 1'b1;
                if (adv) begin
                    presc <= '0;
                    sec   <= n_sec;
                    min   <= n_min;
                    hour  <= n_hour;
                    day   <= n_day;
                    mon   <= n_mon;
                    year  <= n_year;
                    tick  <= 1'b1;
                end else if (en) begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Randomized + directed bench for rtc_calendar_counter against a
// seconds-of-day / calendar-table reference model.
module tb_rtc_calendar_counter;

    localparam int CF = 4;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [5:0]  ld_sec, ld_min;
    logic [4:0]  ld_hour, ld_day;
    logic [3:0]  ld_mon;
    logic [13:0] ld_year;
    logic [5:0]  sec, min;
    logic [4:0]  hour, day;
    logic [3:0]  mon;
    logic [13:0] year;
    logic        tick, load_err;

    int n_cmp = 0;
    int n_bad = 0;

    int m_ps, m_sec, m_min, m_hour, m_day, m_mon, m_year, m_tick, m_err;

    rtc_calendar_counter #(.CLK_FREQ(CF), .RESET_YEAR(2000)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
        .ld_day(ld_day), .ld_mon(ld_mon), .ld_year(ld_year),
        .sec(sec), .min(min), .hour(hour), .day(day), .mon(mon),
        .year(year), .tick(tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic int is_leap(int y);
        return int'(((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0));
    endfunction

    function automatic int dim(int m, int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12)
            return 0;
        if (m == 2 && is_leap(y) != 0)
            return 29;
        return t[m-1];
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int s;
        bit ok;
        if (rst) begin
            m_ps = 0; m_sec = 0; m_min = 0; m_hour = 0;
            m_day = 1; m_mon = 1; m_year = 2000; m_tick = 0; m_err = 0;
            return;
        end
        m_tick = 0;
        m_err = 0;
        ok = (int'(ld_sec) <= 59) && (int'(ld_min) <= 59) &&
             (int'(ld_hour) <= 23) && (int'(ld_year) <= 9999) &&
             (int'(ld_day) >= 1) &&
             (int'(ld_day) <= dim(int'(ld_mon), int'(ld_year)));
        if (load && ok) begin
            m_ps = 0;
            m_sec = int'(ld_sec); m_min = int'(ld_min);
            m_hour = int'(ld_hour); m_day = int'(ld_day);
            m_mon = int'(ld_mon); m_year = int'(ld_year);
            return;
        end
        if (load)
            m_err = 1;
        if (!en)
            return;
        if (m_ps != CF - 1) begin
            m_ps++;
            return;
        end
        m_ps = 0;
        m_tick = 1;
        s = m_sec + 60 * m_min + 3600 * m_hour + 1;
        if (s == 86400) begin
            s = 0;
            m_day++;
            if (m_day > dim(m_mon, m_year)) begin
                m_day = 1;
                m_mon++;
                if (m_mon > 12) begin
                    m_mon = 1;
                    m_year = (m_year + 1) % 10000;
                end
            end
        end
        m_sec = s % 60;
        m_min = (s / 60) % 60;
        m_hour = s / 3600;
    endtask

    task automatic compare_all();
        chk("sec", int'(sec), m_sec);
        chk("min", int'(min), m_min);
        chk("hour", int'(hour), m_hour);
        chk("day", int'(day), m_day);
        chk("mon", int'(mon), m_mon);
        chk("year", int'(year), m_year);
        chk("tick", int'(tick), m_tick);
        chk("load_err", int'(load_err), m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_load(int h, int mi, int s, int d, int mo, int y);
        ld_sec = 6'(s); ld_min = 6'(mi); ld_hour = 5'(h);
        ld_day = 5'(d); ld_mon = 4'(mo); ld_year = 14'(y);
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_tick(string nm);
        bit got = 0;
        for (int i = 0; i < 3 * CF; i++) begin
            cycle();
            if (tick) begin
                got = 1;
                break;
            end
        end
        chk({nm, "_tick_seen"}, int'(got), 1);
    endtask

    task automatic leap_case(string nm, int d, int mo, int y, int ed, int emo);
        do_load(23, 59, 59, d, mo, y);
        wait_tick(nm);
        chk({nm, "_day"}, int'(day), ed);
        chk({nm, "_mon"}, int'(mon), emo);
        chk({nm, "_year"}, int'(year), y);
    endtask

    initial begin
        int tc[3];
        int ts[3];
        int nt;
        int n;
        int s0;
        rst = 1'b1; en = 1'b0; load = 1'b0;
        ld_sec = '0; ld_min = '0; ld_hour = '0;
        ld_day = '0; ld_mon = '0; ld_year = '0;
        cycle();
        cycle();
        chk("rst_sec", int'(sec), 0);
        chk("rst_day", int'(day), 1);
        chk("rst_mon", int'(mon), 1);
        chk("rst_year", int'(year), 2000);
        chk("rst_tick", int'(tick), 0);

        // 1: tick cadence after reset release
        rst = 1'b0; en = 1'b1;
        nt = 0;
        tc = '{-1, -1, -1};
        ts = '{-1, -1, -1};
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (tick && nt < 3) begin
                tc[nt] = k;
                ts[nt] = int'(sec);
                nt++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk("t1_tick_cycle", tc[i], 4 * (i + 1));
            chk("t1_tick_sec", ts[i], i + 1);
        end

        // 2: full year rollover
        do_load(23, 59, 59, 31, 12, 2023);
        wait_tick("t2");
        chk("t2_hms", int'(hour) + int'(min) + int'(sec), 0);
        chk("t2_day", int'(day), 1);
        chk("t2_mon", int'(mon), 1);
        chk("t2_year", int'(year), 2024);

        // 3: leap years
        leap_case("t3a", 28, 2, 2024, 29, 2);
        leap_case("t3b", 28, 2, 2023, 1, 3);
        leap_case("t3c", 28, 2, 2100, 1, 3);
        leap_case("t3d", 28, 2, 2000, 29, 2);
        leap_case("t3e", 29, 2, 2024, 1, 3);

        // 4: rejected loads
        do_load(1, 2, 3, 31, 4, 2020);
        chk("t4a_err", int'(load_err), 1);
        cycle();
        chk("t4a_err_clr", int'(load_err), 0);
        do_load(1, 2, 3, 29, 2, 2023);
        chk("t4b_err", int'(load_err), 1);
        do_load(1, 2, 3, 1, 0, 2023);
        chk("t4c_err", int'(load_err), 1);
        do_load(24, 0, 0, 1, 1, 2023);
        chk("t4d_err", int'(load_err), 1);
        wait_tick("t4");

        // 5: valid load on the advance-event cycle
        for (int i = 0; i < 2 * CF; i++) begin
            if (m_ps == CF - 1)
                break;
            cycle();
        end
        do_load(10, 20, 30, 15, 6, 2022);
        chk("t5_tick", int'(tick), 0);
        chk("t5_sec", int'(sec), 30);
        n = 0;
        for (int i = 0; i < 3 * CF; i++) begin
            cycle();
            n++;
            if (tick)
                break;
        end
        chk("t5_next_tick", n, 4);

        // 6: boundaries
        do_load(23, 59, 59, 31, 12, 9999);
        wait_tick("t6a");
        chk("t6a_year", int'(year), 0);
        chk("t6a_mon", int'(mon), 1);
        chk("t6a_day", int'(day), 1);
        en = 1'b0;
        s0 = m_sec;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t6b_no_tick", int'(tick), 0);
            chk("t6b_frozen", int'(sec), s0);
        end
        en = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6c_sec", int'(sec), 0);
        chk("t6c_year", int'(year), 2000);
        wait_tick("t6c");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) begin
                ld_sec = 6'($urandom_range(0, 63));
                ld_min = 6'($urandom_range(0, 61));
                ld_hour = 5'($urandom_range(0, 24));
                ld_mon = 4'($urandom_range(0, 13));
                ld_day = 5'($urandom_range(0, 31));
                ld_year = ($urandom_range(0, 3) == 0) ?
                          14'($urandom_range(9990, 16383)) :
                          14'($urandom_range(0, 9999));
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            cycle();
        end
        rst = 1'b0; load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_counter.md
Name: rtc_calendar_counter

Overview:
Real-time clock and calendar counter that produces binary sec, min, hour, day, mon and year fields.
Its outputs feed the binary-to-BCD digit splitter that drives the display, with port widths matched one-to-one.
An internal prescaler derives a 1 Hz advance from the system clock.
A load port sets the time, with range checking.

Parameters:
CLK_FREQ, 50_000_000, system clock cycles per second (prescaler modulus, >=2)
RESET_YEAR, 2000, year value loaded on reset (0..9999)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
en  input  1  count enable; low freezes prescaler and all fields
load  input  1  one-cycle strobe; apply ld_* values
ld_sec  input  6  load value, 0..59
ld_min  input  6  load value, 0..59
ld_hour  input  5  load value, 0..23
ld_day  input  5  load value, 1..days_in_month
ld_mon  input  4  load value, 1..12
ld_year  input  14  load value, 0..9999
sec  output  6  seconds, registered
min  output  6  minutes, registered
hour  output  5  hours, registered
day  output  5  day of month, registered
mon  output  4  month, registered
year  output  14  year, registered
tick  output  1  high for one cycle when fields have just advanced
load_err  output  1  high for one cycle after a rejected load

Behaviour:
- Reset (sync, active-high, highest priority):
  - sec=0, min=0, hour=0, day=1, mon=1, year=RESET_YEAR.
  - Prescaler=0, tick=0, load_err=0.
- Prescaler:
  - Counts 0..CLK_FREQ-1 while en=1; holds while en=0.
  - Advance event = en && prescaler==CLK_FREQ-1.
  - On an advance event, the prescaler returns to 0.
- Advance, on the clock edge of an advance event:
  - sec increments. 59 wraps to 0 and carries into min.
  - min: 59 wraps to 0 and carries into hour.
  - hour: 23 wraps to 0 and carries into day.
  - day: days_in_month(mon, year) wraps to 1 and carries into mon.
  - mon: 12 wraps to 1 and carries into year.
  - year: 9999 wraps to 0.
  - tick=1 in the cycle after that edge, coincident with the new field values. Otherwise tick=0.
- days_in_month:
  - 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
  - Feb: 29 if leap, else 28.
  - leap = (year%4==0 && year%100!=0) || year%400==0. Year 0 counts as leap.
- Load:
  - Validity checks: ld_sec<=59, ld_min<=59, ld_hour<=23, 1<=ld_mon<=12, 1<=ld_day<=days_in_month(ld_mon, ld_year), ld_year<=9999.
  - Valid load: all fields take the ld_* values at the next edge, prescaler clears to 0, tick=0, load_err=0.
  - Invalid load: all fields and the prescaler are unchanged (the prescaler keeps counting if en=1), tick behaves normally, load_err=1 for one cycle.
  - Load is honoured regardless of en.
- Priority: rst > valid load > advance event.
  - Load coincident with an advance event: the loaded values win and no tick is emitted.
  - Rejected load coincident with an advance event: the advance proceeds normally.
- Reset mid-count: the next cycle shows reset values and the prescaler restarts from 0.
  - First tick arrives CLK_FREQ cycles after rst deasserts (en=1).
- Field updates are single-cycle full ripple carry. There is no intermediate state; all fields change on the same edge.
- Outputs never leave their legal ranges, so the downstream splitter needs no guarding.

Test Plan:
1. CLK_FREQ=4, RESET_YEAR=2000, rst then en=1 -> fields 0:0:0 1/1/2000. tick on cycles 4, 8, 12 after reset release. sec=1, 2, 3.
2. Valid load 23:59:59 31/12/2023, one advance -> 0:0:0 1/1/2024 and tick=1 in the same cycle.
3. Leap day:
   - 23:59:59 28/2/2024 -> 29/2/2024.
   - 28/2/2023 -> 1/3.
   - 28/2/2100 -> 1/3.
   - 28/2/2000 -> 29/2.
   - Loaded 29/2/2024 -> 1/3/2024.
4. Rejections:
   - Load day=31 mon=4 -> fields unchanged, load_err=1 for one cycle, ticks continue on schedule.
   - Load day=29 mon=2 year=2023 -> rejected.
   - Load mon=0 -> rejected.
   - Load hour=24 -> rejected.
5. Load asserted on the advance-event cycle -> loaded values held, no tick; next tick exactly 4 cycles later.
6. Boundaries:
   - Load 23:59:59 31/12/9999, advance -> 0:0:0 1/1/0000.
   - en=0 for 10 cycles -> no tick, fields frozen.
   - rst asserted mid-prescale -> reset values next cycle.
